// File: rtl/imm_extend_buf.sv
// Registered immediate extender feeding a two-entry elastic buffer between decode and the ALU
// operand mux. Immediates are widened on entry and leave in FIFO order.
module imm_extend_buf #(
    parameter int unsigned word_size = 32,
    parameter int unsigned imm_size  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [imm_size-1:0]  imm,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [word_size-1:0] ext_data,
    output logic [1:0]           ext_mode,
    output logic [1:0]           occupancy
);

    localparam int unsigned PadW = word_size - imm_size;

    // State encoding equals the entry count so occupancy is a direct read-out.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [word_size-1:0] head_data_q, head_data_d;
    logic [word_size-1:0] tail_data_q, tail_data_d;
    logic [1:0]           head_mode_q, head_mode_d;
    logic [1:0]           tail_mode_q, tail_mode_d;
    logic [word_size-1:0] sext_in, ext_in;
    logic                 push, pop;

    always_comb begin
        sext_in = {{PadW{imm[imm_size-1]}}, imm};
        unique case (mode)
            2'd0: ext_in = {{PadW{1'b0}}, imm};
            2'd1: ext_in = sext_in;
            2'd2: ext_in = {imm, {PadW{1'b0}}};
            2'd3: ext_in = {sext_in[word_size-3:0], 2'b00};
        endcase
    end

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_mode_d = head_mode_q;
        tail_data_d = tail_data_q;
        tail_mode_d = tail_mode_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        head_data_d = ext_in;
                        head_mode_d = mode;
                        state_d     = StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        head_data_d = ext_in;
                        head_mode_d = mode;
                    end else if (push) begin
                        tail_data_d = ext_in;
                        tail_mode_d = mode;
                        state_d     = StTwo;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_data_d = tail_data_q;
                        head_mode_d = tail_mode_q;
                        state_d     = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            head_data_q <= '0;
            head_mode_q <= '0;
            tail_data_q <= '0;
            tail_mode_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_mode_q <= head_mode_d;
            tail_data_q <= tail_data_d;
            tail_mode_q <= tail_mode_d;
        end
    end

    assign ext_data  = out_valid ? head_data_q : '0;
    assign ext_mode  = out_valid ? head_mode_q : '0;
    assign occupancy = state_q;

endmodule

// File: tb/tb_imm_extend_buf.sv
// Randomised and directed bench for imm_extend_buf, checked against a queue-based reference.
module tb_imm_extend_buf;

    localparam int W = 32;
    localparam int I = 16;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, out_ready;
    logic [I-1:0] imm;
    logic [1:0]   mode;
    logic         in_ready, out_valid;
    logic [W-1:0] ext_data;
    logic [1:0]   ext_mode, occupancy;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] q_data[$];
    logic [1:0]   q_mode[$];

    imm_extend_buf #(.word_size(W), .imm_size(I)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_data  (ext_data),
        .ext_mode  (ext_mode),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Extension computed arithmetically: sign value as a signed integer, upper as a multiply.
    function automatic logic [W-1:0] ref_ext(input logic [I-1:0] v, input logic [1:0] m);
        longint s;
        s = longint'(v);
        if (v[I-1]) s = s - (longint'(1) << I);
        case (m)
            2'd0:    return W'(longint'(v));
            2'd1:    return W'(s);
            2'd2:    return W'(longint'(v) * (longint'(1) << (W - I)));
            default: return W'(s * 4);
        endcase
    endfunction

    task automatic compare_all();
        logic         ev;
        logic [W-1:0] ed;
        logic [1:0]   em;
        ev = (q_data.size() != 0);
        ed = ev ? q_data[0] : '0;
        em = ev ? q_mode[0] : '0;
        check("out_valid", 64'(out_valid), 64'(ev));
        check("ext_data", 64'(ext_data), 64'(ed));
        check("ext_mode", 64'(ext_mode), 64'(em));
        check("occupancy", 64'(occupancy), 64'(q_data.size()));
        check("in_ready", 64'(in_ready), 64'(q_data.size() != 2));
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model, compare at next negedge.
    task automatic cyc(input logic r, input logic f, input logic iv, input logic [I-1:0] d,
                       input logic [1:0] m, input logic ordy);
        bit do_push, do_pop;
        rst_n = r; flush = f; in_valid = iv; imm = d; mode = m; out_ready = ordy;
        @(posedge clk);
        if (!r || f) begin
            q_data.delete();
            q_mode.delete();
        end else begin
            do_push = iv && (q_data.size() < 2);
            do_pop  = ordy && (q_data.size() > 0);
            if (do_pop) begin
                void'(q_data.pop_front());
                void'(q_mode.pop_front());
            end
            if (do_push) begin
                q_data.push_back(ref_ext(d, m));
                q_mode.push_back(m);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 2'd0, ordy);
    endtask

    logic [W-1:0] exp_8001 [4];

    initial begin
        exp_8001[0] = 32'h0000_8001;
        exp_8001[1] = 32'hFFFF_8001;
        exp_8001[2] = 32'h8001_0000;
        exp_8001[3] = 32'hFFFE_0004;

        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b1, 16'h1234, 2'd1, 1'b1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ext_data", 64'(ext_data), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 0x8001 in every mode, one per cycle with out_ready high.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 16'h8001, 2'(k), 1'b1);
            check("mode_8001", 64'(ext_data), 64'(exp_8001[k]));
            check("mode_tag", 64'(ext_mode), 64'(k));
        end
        cyc(1'b1, 1'b0, 1'b1, 16'h1234, 2'd1, 1'b1);
        check("sign_1234", 64'(ext_data), 64'h0000_1234);
        cyc(1'b1, 1'b0, 1'b1, 16'h1234, 2'd3, 1'b1);
        check("branch_1234", 64'(ext_data), 64'h0000_48D0);
        idle(1'b1);

        // Fill with the consumer stalled, then drain in order.
        cyc(1'b1, 1'b0, 1'b1, 16'h0001, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0002, 2'd1, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_occ", 64'(occupancy), 64'd2);
        cyc(1'b1, 1'b0, 1'b1, 16'h0003, 2'd0, 1'b0);
        check("full_reject_occ", 64'(occupancy), 64'd2);
        check("drain_first", 64'(ext_data), 64'h1);
        idle(1'b1);
        check("drain_second", 64'(ext_data), 64'h2);
        idle(1'b1);
        check("drain_empty", 64'(out_valid), 64'd0);

        // Simultaneous push and pop while holding one entry.
        cyc(1'b1, 1'b0, 1'b1, 16'h0005, 2'd0, 1'b1);
        check("one_head", 64'(ext_data), 64'h5);
        cyc(1'b1, 1'b0, 1'b1, 16'h0007, 2'd0, 1'b1);
        check("pushpop_data", 64'(ext_data), 64'h7);
        check("pushpop_occ", 64'(occupancy), 64'd1);
        idle(1'b1);

        // Flush while full, and flush while ready, each with a concurrent push of 0x00AA.
        cyc(1'b1, 1'b0, 1'b1, 16'h0010, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0011, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'h00AA, 2'd0, 1'b1);
        check("flush_full_occ", 64'(occupancy), 64'd0);
        check("flush_full_valid", 64'(out_valid), 64'd0);
        check("flush_full_data", 64'(ext_data), 64'd0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0012, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'h00AA, 2'd0, 1'b0);
        check("flush_one_occ", 64'(occupancy), 64'd0);
        check("flush_one_ready", 64'(in_ready), 64'd1);
        idle(1'b1);
        check("flush_no_aa", 64'(out_valid), 64'd0);

        // Reset mid-stream with two entries held.
        cyc(1'b1, 1'b0, 1'b1, 16'h0020, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0021, 2'd2, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0022, 2'd1, 1'b1);
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_data", 64'(ext_data), 64'd0);
        check("rst2_mode", 64'(ext_mode), 64'd0);
        check("rst2_occ", 64'(occupancy), 64'd0);
        check("rst2_ready", 64'(in_ready), 64'd1);
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFF, 2'd1, 1'b0);
        check("post_rst_ffff", 64'(ext_data), 64'hFFFF_FFFF);

        // Random traffic; flush and reset are rare.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(99) != 0), ($urandom_range(29) == 0), 1'($urandom),
                I'($urandom), 2'($urandom), ($urandom_range(2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
